// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encodings, parameter defaults and counter width for pll_lock_ctrl.
package pll_ctrl_pkg;
  localparam int DEF_RST_CYCLES    = 32;
  localparam int DEF_LOCK_TIMEOUT  = 27000;
  localparam int DEF_STABLE_CYCLES = 2700;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int CNT_W             = 16;
  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;
endpackage

// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if: lock/restart inputs and status outputs of the PLL lock controller.
interface pll_lock_ctrl_if;
  logic       lock;
  logic       restart;
  logic       pll_reset;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;
  logic [2:0] state;
  modport master (output lock, restart, input pll_reset, pll_ready, fault, retry_cnt, unlock_cnt, state);
  modport slave (input lock, restart, output pll_reset, pll_ready, fault, retry_cnt, unlock_cnt, state);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, async reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], i_d};
  end
  assign o_q = r_sync[1];
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: sequences PLL reset, waits for lock with timeout/retry, and qualifies a stable lock.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic           clkin,
  input  logic           reset,
  pll_lock_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);
  logic             w_lock_s;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry, w_retry_nx;
  logic [7:0]       r_unlock, w_unlock_nx;
  logic             r_pll_reset, r_pll_ready, r_fault;
  logic             w_cnt_clr;
  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .i_d (bus.lock),
    .o_q (w_lock_s)
  );
  always_comb begin
    w_state_nx  = r_state;
    w_retry_nx  = r_retry;
    w_unlock_nx = r_unlock;
    if (bus.restart) begin
      w_state_nx = ST_RST_PLL;
      w_retry_nx = '0;
    end else begin
      case (r_state)
        ST_RST_PLL:   w_state_nx = (r_cnt == RST_LAST) ? ST_WAIT_LOCK : ST_RST_PLL;
        ST_WAIT_LOCK: begin
          if (w_lock_s) w_state_nx = ST_STABLE;
          else if (r_cnt == TO_LAST) begin
            w_retry_nx = r_retry + 4'd1;
            w_state_nx = (r_retry + 4'd1 == RETRY_MAX) ? ST_FAULT : ST_RST_PLL;
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) w_state_nx = ST_WAIT_LOCK;
          else if (r_cnt == STB_LAST) begin
            w_state_nx = ST_READY;
            w_retry_nx = '0;
          end
        end
        ST_READY: begin
          if (!w_lock_s) begin
            w_state_nx  = ST_RST_PLL;
            w_unlock_nx = r_unlock + 8'(r_unlock != 8'hFF);
          end
        end
        ST_FAULT: w_state_nx = ST_FAULT;
        default:  w_state_nx = ST_RST_PLL;
      endcase
    end
    // restart inside RST_PLL keeps the state but must still restart the hold count
    w_cnt_clr = bus.restart || (w_state_nx != r_state);
  end
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RST_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_unlock    <= '0;
      r_pll_reset <= 1'b1;
      r_pll_ready <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      r_retry     <= w_retry_nx;
      r_unlock    <= w_unlock_nx;
      r_pll_reset <= (w_state_nx == ST_RST_PLL) || (w_state_nx == ST_FAULT);
      r_pll_ready <= (w_state_nx == ST_READY);
      r_fault     <= (w_state_nx == ST_FAULT);
    end
  end
  assign bus.pll_reset  = r_pll_reset;
  assign bus.pll_ready  = r_pll_ready;
  assign bus.fault      = r_fault;
  assign bus.retry_cnt  = r_retry;
  assign bus.unlock_cnt = r_unlock;
  assign bus.state      = r_state;
endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 32: cycles pll_reset is held high per reset attempt (>=2).
REQ-002 Parameter LOCK_TIMEOUT, default 27000: cycles allowed for lock after pll_reset release (1 ms at 27 MHz).
REQ-003 Parameter STABLE_CYCLES, default 2700: consecutive synchronized-lock-high cycles before pll_ready asserts.
REQ-004 Parameter MAX_RETRY, default 3: consecutive failed attempts before FAULT (1..15).
REQ-005 clkin  in  1  27 MHz system clock, sole clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 lock  in  1  PLL lock, asynchronous to clkin.
REQ-008 restart  in  1  single-cycle soft-restart request, synchronous to clkin.
REQ-009 pll_reset  out  1  drives PLL RESET, active-high.
REQ-010 pll_ready  out  1  PLL output clock valid and stable.
REQ-011 fault  out  1  retry budget exhausted.
REQ-012 retry_cnt  out  4  failed attempts since last success or restart.
REQ-013 unlock_cnt  out  8  lock losses while READY, saturating at 255.
REQ-014 state  out  3  current FSM state encoding, for debug.

Function
REQ-015 lock SHALL pass through a 2-flop synchronizer (lock_s) before any use.
REQ-016 FSM states: RST_PLL, WAIT_LOCK, STABLE, READY, FAULT; one cycle counter (>=16 bits) shared by all states, cleared on every state change.
REQ-017 RST_PLL: pll_reset=1; after RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE; counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> retry_cnt+1, then FAULT if new value == MAX_RETRY, else RST_PLL.
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK with timeout counter restarted; STABLE_CYCLES consecutive lock_s=1 -> READY, retry_cnt cleared.
REQ-020 READY: pll_ready=1; lock_s=0 -> RST_PLL, unlock_cnt+1 (saturating), pll_ready=0 from next cycle.
REQ-021 FAULT: pll_reset=1, fault=1, pll_ready=0; exit only via restart or reset.
REQ-022 restart=1 in any state -> RST_PLL next cycle, retry_cnt cleared, unlock_cnt unchanged.
REQ-023 restart and lock_s fall in the same READY cycle: restart wins; unlock_cnt not incremented.
REQ-024 restart during RST_PLL restarts the full RST_CYCLES hold.
REQ-025 All outputs registered; lock falling edge to pll_ready low = at most 3 clkin cycles.
REQ-026 pll_ready and pll_reset never both 1; fault=1 only in FAULT.

Reset
REQ-027 reset=1 asynchronously forces: state=RST_PLL, pll_reset=1, pll_ready=0, fault=0, retry_cnt=0, unlock_cnt=0, counter=0, synchronizer flops=0.
REQ-028 After reset release, RST_PLL holds a full RST_CYCLES count from zero.
REQ-029 reset asserted mid-operation (any state) takes effect immediately, without waiting for a clock edge.

Structure
REQ-030 State encodings and parameter defaults live in shared package pll_ctrl_pkg.
REQ-031 Lock synchronizer is a separate sub-module sync_2ff (1-bit, async active-high reset to 0).
REQ-032 Target 120-400 lines RTL; no clock gating, no second clock domain.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-033 Release reset, lock high 3 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; pll_ready rises 2+1+8 cycles after lock, retry_cnt=0.
REQ-034 Lock held low -> two 16-cycle timeouts, retry_cnt 1 then 2, fault=1, pll_reset=1; restart pulse -> fault=0, retry_cnt=0, pll_reset high 4 cycles.
REQ-035 In READY, drop lock -> pll_ready low within 3 cycles, unlock_cnt=1, pll_reset high 4 cycles, relock -> READY.
REQ-036 In STABLE, drop lock at stable count 5 -> WAIT_LOCK, pll_ready stays 0, full 8 cycles required after relock.
REQ-037 Restart coincident with lock_s fall in READY -> RST_PLL, unlock_cnt unchanged; 256 lock losses -> unlock_cnt=255.
REQ-038 Assert reset mid-WAIT_LOCK between clock edges -> pll_reset=1, counters 0 immediately.
